// File: rtl/count_bcd_display_pkg.sv
// ============================================================================
// Module : count_bcd_display_pkg
// Brief  : Shared FSM encoding and sizing constants for the BCD display path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package count_bcd_display_pkg;

  localparam int DIGIT_W    = 4;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DIGITS = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/count_bcd_display_bcd_digit_adj.sv
// ============================================================================
// Module : bcd_digit_adj
// Brief  : Double-dabble digit cell; adds 3 to a BCD digit that is 5 or more.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj
  import count_bcd_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

`default_nettype wire

// File: rtl/count_bcd_display.sv
// ============================================================================
// Module : count_bcd_display
// Brief  : Iterative binary-to-BCD converter with sticky overflow flag.
//          Optional macro BCD_BLANK_EN adds leading-zero blanking (blankOut).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module count_bcd_display
  import count_bcd_display_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                      CLK,
  input  logic                      clear,
  input  logic [WIDTH-1:0]          countIn,
  input  logic                      oFlowIn,
  input  logic                      start,
  input  logic                      flagAck,
  output logic                      busy,
  output logic                      valid,
  output logic [DIGIT_W*DIGITS-1:0] bcdOut,
  output logic                      oFlowFlag
`ifdef BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]         blankOut
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = DIGIT_W * DIGITS;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   bin_q,   bin_d;
  logic [BCD_W-1:0]   scr_q,   scr_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [BCD_W-1:0]   bcd_q,   bcd_d;
  logic               valid_q, valid_d;
  logic               flag_q,  flag_d;
  logic [BCD_W-1:0]   w_adj;

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit_i (scr_q[g*DIGIT_W +: DIGIT_W]),
        .digit_o (w_adj[g*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d   = countIn;
          scr_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {scr_d, bin_d} = {w_adj, bin_q} << 1;
        cnt_d          = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d   = scr_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A new overflow outranks an acknowledge on the same edge.
    flag_d = oFlowIn ? 1'b1 : (flagAck ? 1'b0 : flag_q);
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      flag_q  <= flag_d;
    end
  end

  assign busy      = (state_q == ST_SHIFT);
  assign valid     = valid_q;
  assign bcdOut    = bcd_q;
  assign oFlowFlag = flag_q;

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;

  // Scan from the most significant digit down; digit 0 always stays lit.
  always_comb begin
    logic zero_hi;
    zero_hi = 1'b1;
    blank_d = blank_q;
    if (state_q == ST_DONE) begin
      for (int i = DIGITS - 1; i >= 0; i--) begin
        zero_hi    = zero_hi & (scr_q[i*DIGIT_W +: DIGIT_W] == '0);
        blank_d[i] = (i != 0) && zero_hi;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (clear) blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
    else       blank_q <= blank_d;
  end

  assign blankOut = blank_q;
`endif

endmodule

`default_nettype wire
